// File: rtl/mtm_alu_deserializer.sv
// Serial front end of the mtm ALU: parses 11-bit frames from sin into an operand/opcode
// request, validates frame count, CRC and opcode, and emits one valid-or-error pulse.
module mtm_alu_deserializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_op,
  output logic              out_err,
  output logic [2:0]        err_flags
);

  localparam int OPR_W = 2 * DATA_W;
  localparam int MSG_W = OPR_W + 4;
  localparam logic [3:0] FRAMES = 4'(OPR_W / 8);
  localparam logic [3:0] DCNT_MAX = FRAMES + 4'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX      = 2'd1,
    WAIT_HI = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [3:0]         bcnt, bcnt_nx;
  logic [9:0]         shreg, shreg_nx;
  logic [OPR_W-1:0]   opreg, opreg_nx;
  logic [3:0]         dcnt, dcnt_nx;
  logic               valid_nx, err_nx;
  logic [2:0]         flags_nx, op_nx;
  logic [DATA_W-1:0]  a_nx, b_nx;
  logic [9:0]         frame;
  logic [2:0]         cmd_op;
  logic [3:0]         cmd_crc;

  // Bit-serial CRC, g(x) = x^4 + x + 1, init 0, no final xor.
  function automatic logic [3:0] crc_calc(input logic [MSG_W-1:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = MSG_W - 1; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // frame = {type, payload[7:0], stop}, complete when the stop bit is on sin
  assign frame   = {shreg[8:0], sin};
  assign cmd_op  = frame[7:5];
  assign cmd_crc = frame[4:1];

  always_comb begin
    state_nx = state;
    bcnt_nx  = bcnt;
    shreg_nx = shreg;
    opreg_nx = opreg;
    dcnt_nx  = dcnt;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    flags_nx = 3'b000;
    op_nx    = out_op;
    a_nx     = out_a;
    b_nx     = out_b;
    case (state)
      IDLE: begin
        if (!sin) begin
          state_nx = RX;
          bcnt_nx  = 4'd0;
        end
      end
      RX: begin
        shreg_nx = frame;
        bcnt_nx  = bcnt + 4'd1;
        if (bcnt == 4'd9) begin
          state_nx = IDLE;
          if (!sin) begin
            state_nx = WAIT_HI;
            err_nx   = 1'b1;
            flags_nx = 3'b100;
            dcnt_nx  = 4'd0;
          end else if (!frame[9]) begin
            opreg_nx = {opreg[OPR_W-9:0], frame[8:1]};
            dcnt_nx  = (dcnt == DCNT_MAX) ? DCNT_MAX : dcnt + 4'd1;
          end else begin
            dcnt_nx = 4'd0;
            if (dcnt != FRAMES) begin
              err_nx   = 1'b1;
              flags_nx = 3'b100;
            end else if (crc_calc({opreg, 1'b1, cmd_op}) != cmd_crc) begin
              err_nx   = 1'b1;
              flags_nx = 3'b010;
            end else if (!(cmd_op inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
              err_nx   = 1'b1;
              flags_nx = 3'b001;
            end else begin
              valid_nx = 1'b1;
              b_nx     = opreg[OPR_W-1:DATA_W];
              a_nx     = opreg[DATA_W-1:0];
              op_nx    = cmd_op;
            end
          end
        end
      end
      WAIT_HI: begin
        if (sin) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bcnt      <= '0;
      shreg     <= '0;
      opreg     <= '0;
      dcnt      <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      err_flags <= '0;
      out_op    <= '0;
      out_a     <= '0;
      out_b     <= '0;
    end else begin
      state     <= state_nx;
      bcnt      <= bcnt_nx;
      shreg     <= shreg_nx;
      opreg     <= opreg_nx;
      dcnt      <= dcnt_nx;
      out_valid <= valid_nx;
      out_err   <= err_nx;
      err_flags <= flags_nx;
      out_op    <= op_nx;
      out_a     <= a_nx;
      out_b     <= b_nx;
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Bench for mtm_alu_deserializer: serial driver tasks, output pulses checked against an
// expected queue filled as requests are driven, vector table plus multi-cycle sequences.
module tb_mtm_alu_deserializer;

  localparam int W  = 32;
  localparam int EW = 72;

  logic          clk, rst_n, sin;
  logic          out_valid, out_err;
  logic [W-1:0]  out_a, out_b;
  logic [2:0]    out_op, err_flags;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [EW-1:0] exp_q[$];
  int            valid_times[$];

  mtm_alu_deserializer #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_op(out_op),
    .out_err(out_err), .err_flags(err_flags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [EW-1:0] pk(input logic v, input logic e, input logic [2:0] f,
                                       input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    return {v, e, f, op, a, b};
  endfunction

  // reference CRC: remainder of msg * x^4 divided by x^4 + x + 1
  function automatic logic [3:0] ref_crc(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] ref_flags(input logic [2:0] op, input logic [3:0] cx);
    if (cx != 4'd0) return 3'b010;
    if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) return 3'b001;
    return 3'b000;
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every pulse pops one expectation
  always @(negedge clk) begin
    logic [EW-1:0] obs, e;
    if (rst_n && (out_valid || out_err)) begin
      obs = out_valid ? pk(out_valid, out_err, err_flags, out_op, out_a, out_b)
                      : pk(1'b0, out_err, err_flags, 3'b0, '0, '0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got %h expected none", obs);
      end else begin
        e = exp_q.pop_front();
        chk("pulse", obs, e);
      end
      if (out_valid) valid_times.push_back(cyc);
    end
  end

  // driver tasks
  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] payload, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(payload[i]);
    send_bit(stop);
  endtask

  task automatic send_data(input logic [W-1:0] b, input logic [W-1:0] a);
    logic [2*W-1:0] d;
    d = {b, a};
    for (int i = 2 * W / 8 - 1; i >= 0; i--) send_frame(1'b0, d[i*8 +: 8], 1'b1);
  endtask

  task automatic send_cmd(input logic [W-1:0] b, input logic [W-1:0] a, input logic [2:0] op,
                          input logic [3:0] cx);
    logic [3:0] c;
    c = ref_crc({b, a, 1'b1, op}) ^ cx;
    send_frame(1'b1, {1'b0, op, c}, 1'b1);
  endtask

  // push expectation and drive a full request
  task automatic request(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic [3:0] cx);
    logic [2:0] f;
    f = ref_flags(op, cx);
    if (f == 3'b000) exp_q.push_back(pk(1'b1, 1'b0, 3'b000, op, a, b));
    else             exp_q.push_back(pk(1'b0, 1'b1, f, 3'b0, '0, '0));
    send_data(b, a);
    send_cmd(b, a, op, cx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d pulses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [3:0]   cx;
    logic [2:0]   flags;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 32'd10,         b: 32'd20,         op: 3'b100, cx: 4'h0, flags: 3'b000};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          op: 3'b101, cx: 4'h1, flags: 3'b010};
    vecs[2] = '{a: 32'd5,          b: 32'd3,          op: 3'b010, cx: 4'h0, flags: 3'b001};
    vecs[3] = '{a: 32'hDEAD_BEEF,  b: 32'h1234_5678,  op: 3'b001, cx: 4'h0, flags: 3'b000};
    vecs[4] = '{a: 32'd0,          b: 32'd0,          op: 3'b000, cx: 4'h0, flags: 3'b000};
    vecs[5] = '{a: 32'h8000_0000,  b: 32'h7FFF_FFFF,  op: 3'b011, cx: 4'h0, flags: 3'b001};
    vecs[6] = '{a: 32'd1,          b: 32'd2,          op: 3'b111, cx: 4'h8, flags: 3'b010};

    sin   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", pk(out_valid, out_err, err_flags, out_op, out_a, out_b), '0);
    rst_n = 1'b1;
    idle(3);

    // vector table with hand-written expected flags
    foreach (vecs[i]) begin
      if (vecs[i].flags == 3'b000)
        exp_q.push_back(pk(1'b1, 1'b0, 3'b000, vecs[i].op, vecs[i].a, vecs[i].b));
      else
        exp_q.push_back(pk(1'b0, 1'b1, vecs[i].flags, 3'b0, '0, '0));
      send_data(vecs[i].b, vecs[i].a);
      send_cmd(vecs[i].b, vecs[i].a, vecs[i].op, vecs[i].cx);
      idle(2);
      drain("vec");
    end

    // random requests
    for (int i = 0; i < 6; i++) begin
      logic [3:0] cx;
      cx = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      request($urandom, $urandom, 3'($urandom_range(0, 7)), cx);
      idle($urandom_range(0, 3));
      drain("rand");
    end

    // too few, then too many data frames
    exp_q.push_back(pk(1'b0, 1'b1, 3'b100, 3'b0, '0, '0));
    for (int i = 0; i < 7; i++) send_frame(1'b0, 8'($urandom_range(0, 255)), 1'b1);
    send_cmd(32'd2, 32'd1, 3'b000, 4'h0);
    drain("short");
    exp_q.push_back(pk(1'b0, 1'b1, 3'b100, 3'b0, '0, '0));
    for (int i = 0; i < 9; i++) send_frame(1'b0, 8'($urandom_range(0, 255)), 1'b1);
    send_cmd(32'd2, 32'd1, 3'b000, 4'h0);
    drain("long");
    request(32'd1, 32'd2, 3'b000, 4'h0);
    idle(1);
    drain("after_count");

    // framing error in third data frame
    exp_q.push_back(pk(1'b0, 1'b1, 3'b100, 3'b0, '0, '0));
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b0, 8'h33, 1'b0);
    idle(3);
    drain("framing");
    request(32'hCAFE_0001, 32'h0BAD_F00D, 3'b101, 4'h0);
    idle(1);
    drain("after_framing");

    // reset during the fifth data frame
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'hA5, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    sin   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_reset_outputs", pk(out_valid, out_err, err_flags, out_op, out_a, out_b), '0);
    end
    rst_n = 1'b1;
    idle(2);
    request(32'd7, 32'd9, 3'b001, 4'h0);
    idle(1);
    drain("after_reset");

    // back-to-back good requests with no idle bits
    valid_times.delete();
    request(32'h0000_0100, 32'h0000_0200, 3'b100, 4'h0);
    request(32'h0000_0300, 32'h0000_0400, 3'b000, 4'h0);
    idle(2);
    drain("b2b");
    if (valid_times.size() == 2) begin
      chk("b2b_spacing", EW'(valid_times[1] - valid_times[0]), EW'(99));
    end else begin
      checks++;
      errors++;
      $display("FAIL b2b_count: got %0d valid pulses expected 2", valid_times.size());
    end

    idle(5);
    chk("queue_empty", EW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
